// File: rtl/vivo_arb_pkg.sv
// Shared types and helpers for the vivo_fifo push-port arbiter.
// Optional statistics are enabled with the VIVO_ARB_STATS_EN macro.
package vivo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vivo_rr_pick.sv
// Combinational rotate-priority picker: lowest set request at or after ptr, wrapping.
module vivo_rr_pick
  import vivo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Second loop overrides the wrapped winner whenever a request exists at/after ptr.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) idx = IW'(i);
    end
  end

endmodule

// File: rtl/vivo_push_arb.sv
// Packet-aware round-robin arbiter in front of a vivo_fifo push port.
// Define VIVO_ARB_STATS_EN to add per-producer element and packet counters.
module vivo_push_arb
  import vivo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ELEM_WIDTH   = 8,
  parameter int IN_ELEMS_MAX = 4,
  parameter int STAT_W       = 32,
  parameter int NW           = $clog2(IN_ELEMS_MAX + 1),
  parameter int IW           = id_w(NUM_REQ)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  output logic [NUM_REQ-1:0]                                   req_ready,
  input  logic [NUM_REQ-1:0][IN_ELEMS_MAX-1:0][ELEM_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0][NW-1:0]                           req_num_elems,
  input  logic [NUM_REQ-1:0]                                   req_last,
  output logic                                                 fifo_in_valid,
  input  logic                                                 fifo_in_ready,
  output logic [IN_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]              fifo_in_data,
  output logic [NW-1:0]                                        fifo_in_num_elems,
  output logic [IW-1:0]                                        grant_id,
  output logic                                                 grant_locked
`ifdef VIVO_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]                       stat_elems,
  output logic [NUM_REQ-1:0][STAT_W-1:0]                       stat_pkts
`endif
);

  arb_state_e    state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [NW-1:0] sel_num;
  logic          sel_zero;
  logic          sel_last;
  logic          accept;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + IW'(1);
  endfunction

  vivo_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Selection never looks at fifo_in_ready, which keeps the fifo's
  // num_elems -> in_ready path free of a combinational loop.
  always_comb begin
    sel      = (state_q == ARB_LOCKED) ? owner_q : pick_idx;
    sel_vld  = (state_q == ARB_LOCKED) ? req_valid[sel] : pick_any;
    sel_num  = req_num_elems[sel];
    sel_zero = (sel_num == '0);
    sel_last = req_last[sel];
    accept   = sel_vld && (fifo_in_ready || sel_zero);

    fifo_in_valid     = sel_vld && !sel_zero;
    fifo_in_data      = sel_vld ? req_data[sel] : '0;
    fifo_in_num_elems = sel_vld ? sel_num : '0;
    grant_id          = sel;

    req_ready      = '0;
    req_ready[sel] = accept;
  end

  // Zero-element beats are absorbed here but still close a packet on last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      grant_locked <= 1'b0;
    end else if (accept) begin
      if (sel_last) begin
        state_q      <= ARB_IDLE;
        grant_locked <= 1'b0;
        rr_ptr_q     <= next_ptr(sel);
      end else begin
        state_q      <= ARB_LOCKED;
        grant_locked <= 1'b1;
        owner_q      <= sel;
      end
    end
  end

`ifdef VIVO_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_elems <= '0;
      stat_pkts  <= '0;
    end else if (accept) begin
      if (!sel_zero) stat_elems[sel] <= sat_add(stat_elems[sel], STAT_W'(sel_num));
      if (sel_last)  stat_pkts[sel]  <= sat_add(stat_pkts[sel], STAT_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_vivo_push_arb.sv
// Scoreboard bench for vivo_push_arb; stats scenario runs when VIVO_ARB_STATS_EN is defined.
module tb_vivo_push_arb;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [3:0][3:0][7:0] req_data;
  logic [3:0][2:0]      req_num_elems;
  logic [3:0]           req_last;
  logic                 fifo_in_valid;
  logic                 fifo_in_ready;
  logic [3:0][7:0]      fifo_in_data;
  logic [2:0]           fifo_in_num_elems;
  logic [1:0]           grant_id;
  logic                 grant_locked;
`ifdef VIVO_ARB_STATS_EN
  logic [3:0][31:0]     stat_elems;
  logic [3:0][31:0]     stat_pkts;
`endif

  vivo_push_arb #(
    .NUM_REQ      (4),
    .ELEM_WIDTH   (8),
    .IN_ELEMS_MAX (4),
    .STAT_W       (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_data          (req_data),
    .req_num_elems     (req_num_elems),
    .req_last          (req_last),
    .fifo_in_valid     (fifo_in_valid),
    .fifo_in_ready     (fifo_in_ready),
    .fifo_in_data      (fifo_in_data),
    .fifo_in_num_elems (fifo_in_num_elems),
    .grant_id          (grant_id),
    .grant_locked      (grant_locked)
`ifdef VIVO_ARB_STATS_EN
    ,
    .stat_elems        (stat_elems),
    .stat_pkts         (stat_pkts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          num;
    int          cyc;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  beat_t mb;
  int    cyc = 0;
  int    lock_cnt = 0;
  int    n_pass = 0;
  int    n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Forwarded beats are captured on the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_in_valid && fifo_in_ready) begin
        mb.id   = int'(grant_id);
        mb.data = fifo_in_data;
        mb.num  = int'(fifo_in_num_elems);
        mb.cyc  = cyc;
        obs_q.push_back(mb);
      end
      if (grant_locked) lock_cnt++;
    end
  end

  task automatic expect_beat(input int id, input logic [31:0] data, input int num);
    beat_t b;
    b.id = id; b.data = data; b.num = num; b.cyc = 0;
    exp_q.push_back(b);
  endtask

  task automatic send_pkt(input int r, input int nb, input int n0, input int n1,
                          input int n2, input logic [31:0] base);
    int nums[3];
    nums = '{n0, n1, n2};
    for (int b = 0; b < nb; b++) begin
      int t;
      req_data[r]      = base + b;
      req_num_elems[r] = 3'(nums[b]);
      req_last[r]      = (b == nb - 1);
      req_valid[r]     = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!req_ready[r] && t < 200);
      if (!req_ready[r]) begin
        n_total++;
        $display("FAIL send_r%0d_beat%0d: req_ready=0 after %0d cycles, required 1", r, b, t);
      end
      @(posedge clk); #1;
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (grant_locked === 1'b0) n_pass++; else $display("FAIL rst_locked: got %b, required 0", grant_locked);
    n_total++; if (grant_id === 2'd0) n_pass++; else $display("FAIL rst_grant_id: got %0d, required 0", grant_id);
    n_total++; if (fifo_in_valid === 1'b0) n_pass++; else $display("FAIL rst_fifo_valid: got %b, required 0", fifo_in_valid);
    n_total++; if (fifo_in_data === 32'h0 && fifo_in_num_elems === 3'd0) n_pass++;
    else $display("FAIL rst_fifo_data: got %h/%0d, required 0/0", fifo_in_data, fifo_in_num_elems);
    n_total++; if (req_ready === 4'b0000) n_pass++; else $display("FAIL rst_req_ready: got %b, required 0000", req_ready);
`ifdef VIVO_ARB_STATS_EN
    n_total++; if (stat_elems === '0 && stat_pkts === '0) n_pass++; else $display("FAIL rst_stats: got nonzero, required 0");
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_arbitration();
    obs_q.delete(); exp_q.delete();
    expect_beat(0, 32'hA0A1A2A3, 4);
    expect_beat(2, 32'hC0C1C2C3, 4);
    expect_beat(0, 32'hB0B1B2B3, 4);
    expect_beat(2, 32'hD0D1D2D3, 4);
    fork
      begin send_pkt(0, 1, 4, 0, 0, 32'hA0A1A2A3); send_pkt(0, 1, 4, 0, 0, 32'hB0B1B2B3); end
      begin send_pkt(2, 1, 4, 0, 0, 32'hC0C1C2C3); send_pkt(2, 1, 4, 0, 0, 32'hD0D1D2D3); end
    join
    n_total++; if (obs_q.size() == 4) n_pass++; else $display("FAIL arb_count: got %0d beats, required 4", obs_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (obs_q[k].id === exp_q[k].id && obs_q[k].data === exp_q[k].data && obs_q[k].num === exp_q[k].num) n_pass++;
      else $display("FAIL arb_beat%0d: got id=%0d data=%h num=%0d, required id=%0d data=%h num=%0d", k,
                    obs_q[k].id, obs_q[k].data, obs_q[k].num, exp_q[k].id, exp_q[k].data, exp_q[k].num);
      if (k > 0) begin
        n_total++;
        if (obs_q[k].cyc === obs_q[0].cyc + k) n_pass++;
        else $display("FAIL arb_cycle%0d: got %0d, required %0d", k, obs_q[k].cyc, obs_q[0].cyc + k);
      end
    end
    @(negedge clk);
    n_total++;
    if (fifo_in_valid === 1'b0 && fifo_in_data === 32'h0 && fifo_in_num_elems === 3'd0) n_pass++;
    else $display("FAIL idle_zero: got v=%b d=%h n=%0d, required 0/0/0", fifo_in_valid, fifo_in_data, fifo_in_num_elems);
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    int l0;
    obs_q.delete(); exp_q.delete();
    l0 = lock_cnt;
    expect_beat(1, 32'h1111_0000, 2);
    expect_beat(1, 32'h1111_0001, 3);
    expect_beat(1, 32'h1111_0002, 1);
    expect_beat(0, 32'h0000_0055, 4);
    fork
      send_pkt(1, 3, 2, 3, 1, 32'h1111_0000);
      begin @(posedge clk); #1; send_pkt(0, 1, 4, 0, 0, 32'h0000_0055); end
    join
    n_total++; if (obs_q.size() == 4) n_pass++; else $display("FAIL lock_count: got %0d beats, required 4", obs_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (obs_q[k].id === exp_q[k].id && obs_q[k].data === exp_q[k].data && obs_q[k].num === exp_q[k].num) n_pass++;
      else $display("FAIL lock_beat%0d: got id=%0d data=%h num=%0d, required id=%0d data=%h num=%0d", k,
                    obs_q[k].id, obs_q[k].data, obs_q[k].num, exp_q[k].id, exp_q[k].data, exp_q[k].num);
      if (k > 0) begin
        n_total++;
        if (obs_q[k].cyc === obs_q[0].cyc + k) n_pass++;
        else $display("FAIL lock_cycle%0d: got %0d, required %0d", k, obs_q[k].cyc, obs_q[0].cyc + k);
      end
    end
    n_total++; if (lock_cnt - l0 === 2) n_pass++; else $display("FAIL lock_cycles: got %0d, required 2", lock_cnt - l0);
  endtask

  task automatic test_backpressure();
    obs_q.delete(); exp_q.delete();
    expect_beat(3, 32'h3333_0000, 4);
    expect_beat(3, 32'h3333_0001, 4);
    expect_beat(3, 32'h3333_0002, 4);
    expect_beat(1, 32'h0000_0077, 4);
    fork
      send_pkt(3, 3, 4, 4, 4, 32'h3333_0000);
      begin @(posedge clk); #1; send_pkt(1, 1, 4, 0, 0, 32'h0000_0077); end
      begin
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready[3] && t < 50);
        if (!req_ready[3]) begin
          n_total++;
          $display("FAIL bp_start: req_ready[3]=0 after %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        fifo_in_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_total++; if (req_ready === 4'b0000) n_pass++; else $display("FAIL bp_ready%0d: got %b, required 0000", s, req_ready);
          n_total++; if (grant_id === 2'd3) n_pass++; else $display("FAIL bp_grant%0d: got %0d, required 3", s, grant_id);
        end
        @(posedge clk); #1;
        fifo_in_ready = 1'b1;
      end
    join
    n_total++; if (obs_q.size() == 4) n_pass++; else $display("FAIL bp_count: got %0d beats, required 4", obs_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      n_total++;
      if (obs_q[k].id === exp_q[k].id && obs_q[k].data === exp_q[k].data && obs_q[k].num === exp_q[k].num) n_pass++;
      else $display("FAIL bp_beat%0d: got id=%0d data=%h num=%0d, required id=%0d data=%h num=%0d", k,
                    obs_q[k].id, obs_q[k].data, obs_q[k].num, exp_q[k].id, exp_q[k].data, exp_q[k].num);
    end
    if (obs_q.size() >= 2) begin
      n_total++;
      if (obs_q[1].cyc - obs_q[0].cyc === 6) n_pass++;
      else $display("FAIL bp_resume_gap: got %0d cycles, required 6", obs_q[1].cyc - obs_q[0].cyc);
    end
  endtask

  task automatic test_zero_elem();
    obs_q.delete();
    req_data[3] = 32'hDEAD_BEEF; req_num_elems[3] = 3'd0; req_last[3] = 1'b1; req_valid[3] = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready === 4'b1000) n_pass++; else $display("FAIL zero_ready: got %b, required 1000", req_ready);
    n_total++; if (fifo_in_valid === 1'b0) n_pass++; else $display("FAIL zero_fwd: got %b, required 0", fifo_in_valid);
    n_total++; if (grant_id === 2'd3) n_pass++; else $display("FAIL zero_grant: got %0d, required 3", grant_id);
    @(posedge clk); #1;
    req_valid = 4'b0000; req_last = 4'b0000;
    fifo_in_ready = 1'b0;
    req_num_elems = {3'd1, 3'd1, 3'd1, 3'd1};
    req_valid = 4'b1111;
    @(negedge clk);
    n_total++; if (grant_id === 2'd0) n_pass++; else $display("FAIL zero_rr_ptr: got grant %0d, required 0", grant_id);
    n_total++; if (obs_q.size() == 0) n_pass++; else $display("FAIL zero_not_fwd: got %0d beats, required 0", obs_q.size());
    @(posedge clk); #1;
    req_valid = 4'b0000;
    fifo_in_ready = 1'b1;
  endtask

  task automatic test_reset_locked();
    req_data[1] = 32'h0000_0001; req_num_elems[1] = 3'd2; req_last[1] = 1'b0; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    fifo_in_ready = 1'b0;
    req_data[1] = 32'h0000_0002;
    req_data[2] = 32'h2222_2222; req_num_elems[2] = 3'd3; req_last[2] = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_total++; if (grant_locked === 1'b1) n_pass++; else $display("FAIL rl_locked: got %b, required 1", grant_locked);
    n_total++; if (grant_id === 2'd1) n_pass++; else $display("FAIL rl_owner: got %0d, required 1", grant_id);
    rst_n = 1'b0;
    #1;
    n_total++; if (grant_locked === 1'b0) n_pass++; else $display("FAIL rl_async_locked: got %b, required 0", grant_locked);
    n_total++; if (grant_id === 2'd0) n_pass++; else $display("FAIL rl_async_rr: got %0d, required 0", grant_id);
`ifdef VIVO_ARB_STATS_EN
    n_total++; if (stat_elems === '0 && stat_pkts === '0) n_pass++; else $display("FAIL rl_stats_clear: got nonzero, required 0");
`endif
    req_valid = 4'b0100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fifo_in_ready = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready === 4'b0100) n_pass++; else $display("FAIL rl_r2_ready: got %b, required 0100", req_ready);
    n_total++;
    if (fifo_in_valid === 1'b1 && fifo_in_data === 32'h2222_2222 && fifo_in_num_elems === 3'd3) n_pass++;
    else $display("FAIL rl_r2_fwd: got v=%b d=%h n=%0d, required 1/22222222/3", fifo_in_valid, fifo_in_data, fifo_in_num_elems);
    @(posedge clk); #1;
    req_valid = 4'b0000; req_last = 4'b0000;
  endtask

`ifdef VIVO_ARB_STATS_EN
  task automatic test_stats();
    for (int p = 0; p < 10; p++) send_pkt(1, 2, 3, 3, 0, 32'h0000_5000 + p);
    n_total++; if (stat_elems[1] === 32'd60) n_pass++; else $display("FAIL stat_elems1: got %0d, required 60", stat_elems[1]);
    n_total++; if (stat_pkts[1] === 32'd10) n_pass++; else $display("FAIL stat_pkts1: got %0d, required 10", stat_pkts[1]);
    n_total++; if (stat_elems[2] === 32'd3 && stat_pkts[2] === 32'd1) n_pass++;
    else $display("FAIL stat_r2: got %0d/%0d, required 3/1", stat_elems[2], stat_pkts[2]);
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_last      = '0;
    req_data      = '0;
    req_num_elems = '0;
    fifo_in_ready = 1'b1;
    test_reset();
    test_arbitration();
    test_lock();
    test_backpressure();
    test_zero_elem();
    test_reset_locked();
`ifdef VIVO_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
